// File: rtl/ads131a0x_frame_reader_pkg.sv
// Shared types and constants for the ADS131A0x frame reader.
// Optional CRC checking is enabled with ADS131A0X_FRAME_CRC_EN.
package ads131a0x_frame_reader_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StSsoOn,
        StTxWait,
        StTxWr,
        StRxWait,
        StRxRd,
        StAssemble,
        StSsoOff,
        StDone
    } state_t;

    typedef enum logic [1:0] {
        PhIdle,
        PhStb1,
        PhStb2,
        PhGap
    } bus_phase_t;

    localparam logic [2:0]  AddrRxData  = 3'd0;
    localparam logic [2:0]  AddrTxData  = 3'd1;
    localparam logic [2:0]  AddrControl = 3'd3;

    localparam logic [15:0] SsoCtrlOn   = 16'h0400;
    localparam logic [15:0] CrcPoly     = 16'h1021;
    localparam logic [15:0] CrcSeed     = 16'hFFFF;

    // CRC-16-CCITT advanced by one byte, MSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ CrcPoly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ads131a0x_frame_reader_bus.sv
// Two strobe cycles plus one idle cycle per access on the SPI-master register bus.
// A request is accepted only while idle; done is high during the trailing idle cycle.
module ads131a0x_bus_access
    import ads131a0x_frame_reader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        spi_select,
    output logic        write_n,
    output logic        read_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu
);

    bus_phase_t  phase_q, phase_d;
    logic        sel_q, sel_d;
    logic        wr_n_q, wr_n_d;
    logic        rd_n_q, rd_n_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;

    // Only the low byte carries device data.
    logic unused_rx_hi;
    assign unused_rx_hi = ^data_to_cpu[15:8];

    always_comb begin
        phase_d = phase_q;
        sel_d   = sel_q;
        wr_n_d  = wr_n_q;
        rd_n_d  = rd_n_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (phase_q)
            PhIdle: begin
                if (req) begin
                    phase_d = PhStb1;
                    sel_d   = 1'b1;
                    wr_n_d  = ~we;
                    rd_n_d  = we;
                    addr_d  = addr;
                    wdata_d = we ? wdata : 16'h0000;
                end
            end
            PhStb1: phase_d = PhStb2;
            PhStb2: begin
                phase_d = PhGap;
                sel_d   = 1'b0;
                wr_n_d  = 1'b1;
                rd_n_d  = 1'b1;
                addr_d  = 3'd0;
                wdata_d = 16'h0000;
                if (!rd_n_q) begin
                    rdata_d = data_to_cpu[7:0];
                end
            end
            PhGap:   phase_d = PhIdle;
            default: phase_d = PhIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PhIdle;
            sel_q   <= 1'b0;
            wr_n_q  <= 1'b1;
            rd_n_q  <= 1'b1;
            addr_q  <= 3'd0;
            wdata_q <= 16'h0000;
            rdata_q <= 8'h00;
        end else begin
            phase_q <= phase_d;
            sel_q   <= sel_d;
            wr_n_q  <= wr_n_d;
            rd_n_q  <= rd_n_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign done          = (phase_q == PhGap);
    assign rdata         = rdata_q;
    assign spi_select    = sel_q;
    assign write_n       = wr_n_q;
    assign read_n        = rd_n_q;
    assign mem_addr      = addr_q;
    assign data_from_cpu = wdata_q;

endmodule

// File: rtl/ads131a0x_frame_reader.sv
// Reads one status word plus NUM_CH channel words from an ADS131A0x on each DRDY fall.
// Defining ADS131A0X_FRAME_CRC_EN adds a trailing CRC word and the crc_err output.
module ads131a0x_frame_reader
    import ads131a0x_frame_reader_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned WORD_BYTES = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        drdy_n,
    input  logic        enable,
    output logic        spi_select,
    output logic        write_n,
    output logic        read_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu,
    input  logic        dataavailable,
    input  logic        readyfordata,
    output logic        sample_valid,
    output logic [2:0]  sample_ch,
    output logic [31:0] sample_data,
    output logic [15:0] status_word,
    output logic        frame_done,
    output logic        busy,
`ifdef ADS131A0X_FRAME_CRC_EN
    output logic        crc_err,
`endif
    output logic        drdy_overrun
);

    localparam int unsigned WordBits = WORD_BYTES * 8;
    localparam int unsigned ExtShift = 32 - WordBits;
`ifdef ADS131A0X_FRAME_CRC_EN
    localparam int unsigned NumWords = NUM_CH + 2;
`else
    localparam int unsigned NumWords = NUM_CH + 1;
`endif
    localparam logic [1:0] LastByte = 2'(WORD_BYTES - 1);
    localparam logic [3:0] LastWord = 4'(NumWords - 1);

    state_t                state_q, state_d;
    logic                  drdy_meta_q, drdy_sync_q, drdy_prev_q;
    logic                  drdy_fall, start;
    logic [1:0]            byte_cnt_q, byte_cnt_d;
    logic [3:0]            word_cnt_q, word_cnt_d;
    logic [WordBits-9:0]   prefix_q, prefix_d;
    logic [15:0]           status_hold_q, status_hold_d;
    logic [15:0]           status_word_q, status_word_d;
    logic                  sample_valid_q, sample_valid_d;
    logic [2:0]            sample_ch_q, sample_ch_d;
    logic [31:0]           sample_data_q, sample_data_d;
    logic                  overrun_q;
    logic [WordBits-1:0]   word_full;
    logic [15:0]           word_top16;
    logic [31:0]           word_left, sample_ext;

    logic                  bus_req, bus_we, bus_done;
    logic [2:0]            bus_addr;
    logic [15:0]           bus_wdata;
    logic [7:0]            bus_rdata;

`ifdef ADS131A0X_FRAME_CRC_EN
    logic [15:0]           crc_q, crc_d;
    logic                  crc_bad_q, crc_bad_d;
    logic                  crc_err_q, crc_err_d;
`endif

    assign drdy_fall = drdy_prev_q & ~drdy_sync_q;
    assign start     = drdy_fall & enable & (state_q == StIdle);

    // Word currently being shifted in, including the byte just read.
    always_comb begin
        word_full  = (byte_cnt_q == 2'd0) ? {{(WordBits - 8){1'b0}}, bus_rdata}
                                          : {prefix_q, bus_rdata};
        word_top16 = word_full[WordBits-1 -: 16];
        word_left  = 32'(word_full) << ExtShift;
        sample_ext = 32'($signed(word_left) >>> ExtShift);
    end

    always_comb begin
        state_d        = state_q;
        bus_req        = 1'b0;
        bus_we         = 1'b0;
        bus_addr       = AddrRxData;
        bus_wdata      = 16'h0000;
        byte_cnt_d     = byte_cnt_q;
        word_cnt_d     = word_cnt_q;
        prefix_d       = prefix_q;
        status_hold_d  = status_hold_q;
        status_word_d  = status_word_q;
        sample_valid_d = 1'b0;
        sample_ch_d    = sample_ch_q;
        sample_data_d  = sample_data_q;
`ifdef ADS131A0X_FRAME_CRC_EN
        crc_d          = crc_q;
        crc_bad_d      = crc_bad_q;
        crc_err_d      = crc_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StSsoOn;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 4'd0;
`ifdef ADS131A0X_FRAME_CRC_EN
                    crc_d      = CrcSeed;
                    crc_bad_d  = 1'b0;
`endif
                end
            end
            StSsoOn: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = AddrControl;
                bus_wdata = SsoCtrlOn;
                if (bus_done) state_d = StTxWait;
            end
            StTxWait: begin
                if (readyfordata) state_d = StTxWr;
            end
            StTxWr: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = AddrTxData;
                if (bus_done) state_d = StRxWait;
            end
            StRxWait: begin
                if (dataavailable) state_d = StRxRd;
            end
            StRxRd: begin
                bus_req  = 1'b1;
                bus_addr = AddrRxData;
                if (bus_done) state_d = StAssemble;
            end
            StAssemble: begin
                prefix_d = word_full[WordBits-9:0];
`ifdef ADS131A0X_FRAME_CRC_EN
                if (word_cnt_q != LastWord) crc_d = crc16_byte(crc_q, bus_rdata);
`endif
                if (byte_cnt_q == LastByte) begin
                    byte_cnt_d = 2'd0;
                    if (word_cnt_q == 4'd0) begin
                        status_hold_d = word_top16;
                    end
`ifdef ADS131A0X_FRAME_CRC_EN
                    else if (word_cnt_q == LastWord) begin
                        crc_bad_d = (word_top16 != crc_q);
                    end
`endif
                    else begin
                        sample_valid_d = 1'b1;
                        sample_ch_d    = 3'(word_cnt_q - 4'd1);
                        sample_data_d  = sample_ext;
                    end
                    if (word_cnt_q == LastWord) begin
                        word_cnt_d = 4'd0;
                        state_d    = StSsoOff;
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                        state_d    = StTxWait;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    state_d    = StTxWait;
                end
            end
            StSsoOff: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = AddrControl;
                if (bus_done) begin
                    state_d       = StDone;
                    status_word_d = status_hold_q;
`ifdef ADS131A0X_FRAME_CRC_EN
                    crc_err_d     = crc_bad_q;
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            drdy_meta_q    <= 1'b1;
            drdy_sync_q    <= 1'b1;
            drdy_prev_q    <= 1'b1;
            byte_cnt_q     <= 2'd0;
            word_cnt_q     <= 4'd0;
            prefix_q       <= '0;
            status_hold_q  <= 16'h0000;
            status_word_q  <= 16'h0000;
            sample_valid_q <= 1'b0;
            sample_ch_q    <= 3'd0;
            sample_data_q  <= 32'h0;
            overrun_q      <= 1'b0;
`ifdef ADS131A0X_FRAME_CRC_EN
            crc_q          <= CrcSeed;
            crc_bad_q      <= 1'b0;
            crc_err_q      <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            drdy_meta_q    <= drdy_n;
            drdy_sync_q    <= drdy_meta_q;
            drdy_prev_q    <= drdy_sync_q;
            byte_cnt_q     <= byte_cnt_d;
            word_cnt_q     <= word_cnt_d;
            prefix_q       <= prefix_d;
            status_hold_q  <= status_hold_d;
            status_word_q  <= status_word_d;
            sample_valid_q <= sample_valid_d;
            sample_ch_q    <= sample_ch_d;
            sample_data_q  <= sample_data_d;
            // DONE still counts as busy, so a coincident edge is an overrun.
            overrun_q      <= drdy_fall & (state_q != StIdle);
`ifdef ADS131A0X_FRAME_CRC_EN
            crc_q          <= crc_d;
            crc_bad_q      <= crc_bad_d;
            crc_err_q      <= crc_err_d;
`endif
        end
    end

    ads131a0x_bus_access u_bus (
        .clk           (clk),
        .reset         (reset),
        .req           (bus_req),
        .we            (bus_we),
        .addr          (bus_addr),
        .wdata         (bus_wdata),
        .done          (bus_done),
        .rdata         (bus_rdata),
        .spi_select    (spi_select),
        .write_n       (write_n),
        .read_n        (read_n),
        .mem_addr      (mem_addr),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu)
    );

    assign sample_valid = sample_valid_q;
    assign sample_ch    = sample_ch_q;
    assign sample_data  = sample_data_q;
    assign status_word  = status_word_q;
    assign frame_done   = (state_q == StDone);
    assign busy         = (state_q != StIdle);
    assign drdy_overrun = overrun_q;
`ifdef ADS131A0X_FRAME_CRC_EN
    assign crc_err      = crc_err_q;
`endif

endmodule

// File: tb/tb_ads131a0x_frame_reader.sv
// Scoreboard bench: expected bus accesses, samples and status are queued at stimulus time
// and checked by an independent monitor against a byte-level model of the frame.
module tb_ads131a0x_frame_reader;

    localparam int NUM_CH     = 4;
    localparam int WORD_BYTES = 3;
`ifdef ADS131A0X_FRAME_CRC_EN
    localparam int NUM_WORDS  = NUM_CH + 2;
`else
    localparam int NUM_WORDS  = NUM_CH + 1;
`endif
    localparam int FRAME_BYTES   = NUM_WORDS * WORD_BYTES;
    localparam int PAYLOAD_BYTES = (NUM_CH + 1) * WORD_BYTES;

    typedef struct packed {
        logic        we;
        logic [2:0]  addr;
        logic [15:0] data;
    } acc_t;

    typedef struct packed {
        logic [2:0]  ch;
        logic [31:0] data;
    } smp_t;

    logic        clk = 1'b0;
    logic        reset, drdy_n, enable;
    logic        spi_select, write_n, read_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;
    logic        dataavailable, readyfordata;
    logic        sample_valid, frame_done, busy, drdy_overrun;
    logic [2:0]  sample_ch;
    logic [31:0] sample_data;
    logic [15:0] status_word;
    logic        crc_flag;

    ads131a0x_frame_reader #(
        .NUM_CH     (NUM_CH),
        .WORD_BYTES (WORD_BYTES)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .drdy_n        (drdy_n),
        .enable        (enable),
        .spi_select    (spi_select),
        .write_n       (write_n),
        .read_n        (read_n),
        .mem_addr      (mem_addr),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu),
        .dataavailable (dataavailable),
        .readyfordata  (readyfordata),
        .sample_valid  (sample_valid),
        .sample_ch     (sample_ch),
        .sample_data   (sample_data),
        .status_word   (status_word),
        .frame_done    (frame_done),
        .busy          (busy),
`ifdef ADS131A0X_FRAME_CRC_EN
        .crc_err       (crc_flag),
`endif
        .drdy_overrun  (drdy_overrun)
    );

`ifndef ADS131A0X_FRAME_CRC_EN
    assign crc_flag = 1'b0;
`endif

    always #5 clk = ~clk;

    int   n_tests = 0, n_fail = 0;
    int   n_done = 0, n_wr = 0, n_rd = 0, n_acc = 0, ov_seen = 0, tx_in_hold = 0;
    int   strobe_bad = 0, stb_cnt = 0;
    bit   in_acc = 0, rfd_hold = 0;
    acc_t cur;
    acc_t exp_acc[$];
    smp_t exp_smp[$];
    logic [16:0] exp_stat[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  fbytes[$];
    logic [7:0]  rx_head = 8'h5A;

    // Upper byte is junk that the reader must ignore.
    assign data_to_cpu = {8'hA5, rx_head};

    localparam logic [76:0] RESET_OUTS = {1'b0, 1'b1, 1'b1, 3'd0, 16'd0, 1'b0, 3'd0, 32'd0,
                                          16'd0, 1'b0, 1'b0, 1'b0};

    function automatic logic [76:0] outs();
        return {spi_select, write_n, read_n, mem_addr, data_from_cpu, sample_valid, sample_ch,
                sample_data, status_word, frame_done, busy, drdy_overrun};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic refresh_head();
        rx_head = (rx_q.size() != 0) ? rx_q[0] : 8'h5A;
    endtask

`ifdef ADS131A0X_FRAME_CRC_EN
    function automatic logic [15:0] crc_ccitt(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (q[i]) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ q[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction
`endif

    // Builds the device byte stream from fbytes and queues every expected response.
    task automatic issue_frame(input bit corrupt);
        logic [7:0]  bytes[$];
        logic [15:0] stat;
        logic        exp_err;
        longint      v;
        bytes   = fbytes;
        stat    = 16'h0;
        exp_err = 1'b0;
`ifdef ADS131A0X_FRAME_CRC_EN
        begin
            logic [15:0] crc;
            crc = crc_ccitt(bytes);
            bytes.push_back(crc[15:8]);
            bytes.push_back(crc[7:0]);
            for (int i = 2; i < WORD_BYTES; i++) bytes.push_back(8'h00);
            if (corrupt) begin
                int idx;
                idx = $urandom_range(PAYLOAD_BYTES - 1, 0);
                bytes[idx] = bytes[idx] ^ (8'h01 << $urandom_range(7, 0));
                exp_err = 1'b1;
            end
        end
`else
        if (corrupt) exp_err = 1'b0;
`endif
        for (int w = 0; w <= NUM_CH; w++) begin
            v = 0;
            for (int b = 0; b < WORD_BYTES; b++) v = v * 256 + longint'(bytes[w * WORD_BYTES + b]);
            if (w == 0) begin
                stat = 16'(v >> (WORD_BYTES * 8 - 16));
            end else begin
                if (v >= (longint'(1) << (WORD_BYTES * 8 - 1))) v = v - (longint'(1) << (WORD_BYTES * 8));
                exp_smp.push_back('{ch: 3'(w - 1), data: 32'(v)});
            end
        end
        exp_stat.push_back({exp_err, stat});
        exp_acc.push_back('{we: 1'b1, addr: 3'd3, data: 16'h0400});
        for (int i = 0; i < FRAME_BYTES; i++) begin
            exp_acc.push_back('{we: 1'b1, addr: 3'd1, data: 16'h0000});
            exp_acc.push_back('{we: 1'b0, addr: 3'd0, data: 16'h0000});
        end
        exp_acc.push_back('{we: 1'b1, addr: 3'd3, data: 16'h0000});
        foreach (bytes[i]) rx_q.push_back(bytes[i]);
        refresh_head();
    endtask

    task automatic random_bytes();
        fbytes.delete();
        for (int i = 0; i < PAYLOAD_BYTES; i++) fbytes.push_back(8'($urandom));
    endtask

    task automatic pulse_drdy();
        drdy_n = 1'b0;
        repeat (4) @(negedge clk);
        drdy_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done(input int target, input string name);
        int cyc = 0;
        while (n_done < target && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check(name, 128'(n_done >= target), 128'd1);
    endtask

    // Device handshake flags.
    always @(negedge clk) begin
        readyfordata = rfd_hold ? 1'b0 : ($urandom_range(3, 0) != 0);
        dataavailable = ($urandom_range(2, 0) != 0);
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            in_acc  = 1'b0;
            stb_cnt = 0;
        end else begin
            if (spi_select) begin
                if (!in_acc) begin
                    in_acc   = 1'b1;
                    stb_cnt  = 0;
                    cur.we   = ~write_n;
                    cur.addr = mem_addr;
                    cur.data = data_from_cpu;
                end
                stb_cnt++;
                if (write_n == read_n) strobe_bad++;
            end else begin
                if (!write_n || !read_n) strobe_bad++;
                if (in_acc) begin
                    in_acc = 1'b0;
                    n_acc++;
                    check("bus_strobe_cycles", 128'(stb_cnt), 128'd2);
                    if (exp_acc.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL bus_unexpected: got we=%0b addr=%0d data=%0h expected none",
                                 cur.we, cur.addr, cur.data);
                    end else begin
                        acc_t e;
                        e = exp_acc.pop_front();
                        check("bus_access", {cur.we, cur.addr, cur.we ? cur.data : 16'h0}, e);
                    end
                    if (cur.we) begin
                        n_wr++;
                        if (cur.addr == 3'd1 && rfd_hold) tx_in_hold++;
                    end else begin
                        n_rd++;
                        if (rx_q.size() != 0) void'(rx_q.pop_front());
                        refresh_head();
                    end
                end
            end
            if (sample_valid) begin
                if (exp_smp.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sample_unexpected: got ch=%0d data=%0h expected none",
                             sample_ch, sample_data);
                end else begin
                    smp_t s;
                    s = exp_smp.pop_front();
                    check("sample", {sample_ch, sample_data}, s);
                end
            end
            if (frame_done) begin
                n_done++;
                if (exp_stat.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL frame_unexpected: got status=%0h expected none", status_word);
                end else begin
                    check("frame_status", {crc_flag, status_word}, exp_stat.pop_front());
                end
            end
            if (drdy_overrun) ov_seen++;
        end
    end

    initial begin
        int d0, r0, a0, cyc;
        reset  = 1'b1;
        drdy_n = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 128'(outs()), 128'(RESET_OUTS));
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);

        // Directed frame with the signed boundary values.
        fbytes = '{8'h22, 8'h00, 8'h00, 8'h7F, 8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00,
                   8'h00, 8'h00, 8'h01, 8'hFF, 8'hFF, 8'hFF};
        issue_frame(1'b0);
        pulse_drdy();
        wait_done(1, "t1_frame_done");
        check("t1_writes", 128'(n_wr), 128'(FRAME_BYTES + 2));
        check("t1_reads", 128'(n_rd), 128'(FRAME_BYTES));
        check("t1_status_word", 128'(status_word), 128'h2200);
        repeat (2) @(negedge clk);
        check("t1_idle", 128'(busy), 128'd0);

        // Second DRDY edge while busy is an overrun and is dropped.
        random_bytes();
        issue_frame(1'b0);
        pulse_drdy();
        repeat (30) @(negedge clk);
        check("t2_busy_mid_frame", 128'(busy), 128'd1);
        pulse_drdy();
        wait_done(2, "t2_frame_done");
        repeat (300) @(negedge clk);
        check("t2_no_extra_frame", 128'(n_done), 128'd2);
        check("t2_overrun_pulses", 128'(ov_seen), 128'd1);

        // readyfordata held low: no TX write may go out.
        rfd_hold = 1'b1;
        r0 = n_rd;
        random_bytes();
        issue_frame(1'b1);
        pulse_drdy();
        repeat (50) @(negedge clk);
        check("t3_tx_during_hold", 128'(tx_in_hold), 128'd0);
        check("t3_reads_during_hold", 128'(n_rd - r0), 128'd0);
        rfd_hold = 1'b0;
        wait_done(3, "t3_frame_done");

        // Reset after the seventh byte abandons the frame silently.
        random_bytes();
        issue_frame(1'b0);
        r0  = n_rd;
        cyc = 0;
        pulse_drdy();
        while ((n_rd - r0) < 7 && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_reached_byte7", 128'(n_rd - r0), 128'd7);
        reset = 1'b1;
        exp_acc.delete();
        exp_smp.delete();
        exp_stat.delete();
        rx_q.delete();
        refresh_head();
        @(posedge clk);
        #1;
        check("t4_reset_outputs", 128'(outs()), 128'(RESET_OUTS));
        @(negedge clk);
        reset = 1'b0;
        a0 = n_acc;
        repeat (40) @(negedge clk);
        check("t4_no_bus_after_reset", 128'(n_acc - a0), 128'd0);
        check("t4_frames_after_reset", 128'(n_done), 128'd3);
        random_bytes();
        issue_frame(1'b0);
        pulse_drdy();
        wait_done(4, "t4_recovery_frame");

        // DRDY edge with enable low starts nothing.
        enable = 1'b0;
        d0 = n_done;
        a0 = n_acc;
        pulse_drdy();
        repeat (100) @(negedge clk);
        check("t5_no_frame_when_disabled", 128'(n_done - d0), 128'd0);
        check("t5_no_bus_when_disabled", 128'(n_acc - a0), 128'd0);
        enable = 1'b1;

        // Random frames; enable dropped mid-frame must not abort.
        for (int i = 0; i < 6; i++) begin
            d0 = n_done;
            random_bytes();
            issue_frame(i[0]);
            pulse_drdy();
            repeat ($urandom_range(100, 5)) @(negedge clk);
            enable = 1'b0;
            wait_done(d0 + 1, "t6_frame_done");
            enable = 1'b1;
            repeat ($urandom_range(8, 2)) @(negedge clk);
        end

        repeat (20) @(negedge clk);
        check("end_samples_drained", 128'(exp_smp.size()), 128'd0);
        check("end_bus_drained", 128'(exp_acc.size()), 128'd0);
        check("end_status_drained", 128'(exp_stat.size()), 128'd0);
        check("end_overrun_total", 128'(ov_seen), 128'd1);
        check("end_strobe_protocol", 128'(strobe_bad), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
